// File: rtl/spi_cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_cpu_pkg : opcodes, FSM states, SPI command and uio pin map           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package spi_cpu_pkg;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_LDB  = 4'h1;
  localparam logic [3:0] OP_LDO  = 4'h2;
  localparam logic [3:0] OP_LDSA = 4'h3;
  localparam logic [3:0] OP_LDSB = 4'h4;
  localparam logic [3:0] OP_LSH  = 4'h5;
  localparam logic [3:0] OP_RSH  = 4'h6;
  localparam logic [3:0] OP_CLR  = 4'h7;
  localparam logic [3:0] OP_SNZA = 4'h8;
  localparam logic [3:0] OP_SNZS = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;

  localparam int PIN_CS_N = 0;
  localparam int PIN_MOSI = 1;
  localparam int PIN_MISO = 2;
  localparam int PIN_SCK  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_END  = 3'd4,
    ST_EXH  = 3'd5,
    ST_EXL  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_fetch : SPI mode-0 master, sends READ + address, returns one byte    |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module spi_fetch
  import spi_cpu_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena_i,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 miso_i,
  output logic                 idle_o,
  output logic                 done_o,
  output logic [7:0]           byte_o,
  output logic                 cs_n_o,
  output logic                 sck_o,
  output logic                 mosi_o
);

  localparam int TXW = 8 + ADDR_BITS;
  localparam int CW  = $clog2(TXW);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, last_bit;
  logic           sck_q, sck_d;
  logic           cs_n_q, cs_n_d;
  logic [TXW-1:0] tx_q, tx_d;
  logic [7:0]     rx_q, rx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    last_bit = (state_q == ST_ADDR) ? CW'(ADDR_BITS - 1) : CW'(7);
    case (state_q)
      ST_IDLE: begin
        // Command and address share one shift register; its MSB is MOSI.
        if (ena_i && start_i) begin
          state_d = ST_CMD;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          tx_d    = {SPI_READ_CMD, addr_i};
        end
      end
      ST_CMD, ST_ADDR, ST_DATA: begin
        if (ena_i) begin
          sck_d = ~sck_q;
          if (!sck_q) begin
            if (state_q == ST_DATA) rx_d = {rx_q[6:0], miso_i};
          end else begin
            tx_d = tx_q << 1;
            if (cnt_q == last_bit) begin
              cnt_d = '0;
              case (state_q)
                ST_CMD:  state_d = ST_ADDR;
                ST_ADDR: state_d = ST_DATA;
                default: begin
                  state_d = ST_END;
                  cs_n_d  = 1'b1;
                end
              endcase
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      ST_END: begin
        if (ena_i) begin
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign idle_o = (state_q == ST_IDLE);
  assign done_o = ena_i && (state_q == ST_END) && (cnt_q == CW'(1));
  assign byte_o = rx_q;
  assign cs_n_o = cs_n_q;
  assign sck_o  = sck_q;
  assign mosi_o = tx_q[TXW-1];

endmodule
`default_nettype wire

// File: rtl/spi_cpu_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_cpu_top : 4-bit-opcode CPU fetching its program from SPI RAM         |
// | Option      : SPI_CPU_DBG_PC_EN drives PC[3:0] on uio_out[7:4]           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module spi_cpu_top
  import spi_cpu_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e                 state_q, state_d;
  logic [7:0]             a_q, a_d, b_q, b_d, s_q, s_d, o_q, o_d, ir_q, ir_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic                   skip_q, skip_d, valid_q, valid_d;
  logic [3:0]             nib;
  logic                   fetch_start, fetch_idle, fetch_done;
  logic [7:0]             fetch_byte;
  logic                   cs_n, sck, mosi;

  spi_fetch #(.ADDR_BITS(ADDR_BITS)) u_fetch (
    .clk     (clk),
    .rst     (rst),
    .ena_i   (ena),
    .start_i (fetch_start),
    .addr_i  (pc_q),
    .miso_i  (uio_in[PIN_MISO]),
    .idle_o  (fetch_idle),
    .done_o  (fetch_done),
    .byte_o  (fetch_byte),
    .cs_n_o  (cs_n),
    .sck_o   (sck),
    .mosi_o  (mosi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      o_q     <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      skip_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      o_q     <= o_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    o_d         = o_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    skip_d      = skip_q;
    valid_d     = valid_q;
    fetch_start = 1'b0;
    nib         = (state_q == ST_EXH) ? ir_q[7:4] : ir_q[3:0];
    case (state_q)
      ST_IDLE: begin
        // The fetch engine owns CMD..END; this FSM waits here meanwhile.
        fetch_start = fetch_idle;
        if (fetch_done) begin
          ir_d    = fetch_byte;
          pc_d    = pc_q + ADDR_BITS'(1);
          state_d = ST_EXH;
        end
      end
      ST_EXH, ST_EXL: begin
        if (ena) begin
          state_d = (state_q == ST_EXH) ? ST_EXL : ST_IDLE;
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            case (nib)
              OP_LDA:  a_d = {4'b0, ui_in[3:0]};
              OP_LDB:  b_d = {4'b0, ui_in[7:4]};
              OP_LDO:  begin o_d = s_q; valid_d = 1'b1; end
              OP_LDSA: a_d = s_q;
              OP_LDSB: b_d = s_q;
              OP_LSH:  a_d = a_q << 1;
              OP_RSH:  b_d = b_q >> 1;
              OP_CLR:  begin a_d = '0; b_d = '0; s_d = '0; end
              OP_SNZA: skip_d = (a_q != 8'd0);
              OP_SNZS: skip_d = (s_q != 8'd0);
              OP_ADD:  s_d = a_q + b_q;
              OP_SUB:  s_d = a_q - b_q;
              OP_AND:  s_d = a_q & b_q;
              OP_OR:   s_d = a_q | b_q;
              OP_XOR:  s_d = a_q ^ b_q;
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign uo_out = {valid_q, o_q[6:0]};

  always_comb begin
    uio_out           = 8'h00;
    uio_out[PIN_CS_N] = cs_n;
    uio_out[PIN_MOSI] = mosi;
    uio_out[PIN_SCK]  = sck;
`ifdef SPI_CPU_DBG_PC_EN
    uio_out[7:4]      = pc_q[3:0];
`endif
  end

`ifdef SPI_CPU_DBG_PC_EN
  assign uio_oe = 8'b1111_1011;
`else
  assign uio_oe = 8'b0000_1011;
`endif

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:3], uio_in[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_spi_cpu_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_cpu_top : SPI RAM model plus ISA-level reference for spi_cpu_top   |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_spi_cpu_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  spi_cpu_top #(.ADDR_BITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SPI RAM model
  logic [7:0] ram [256];
  logic       cs_n, sck, mosi, miso_r;
  logic [7:0] junk;
  int         bitn;
  logic [7:0] cmd_sh, addr_sh, last_cmd, last_addr;
  int         last_bits;

  assign cs_n   = uio_out[0];
  assign mosi   = uio_out[1];
  assign sck    = uio_out[3];
  assign uio_in = {junk[7:3], miso_r, junk[1:0]};

  initial begin
    miso_r = 1'b0;
    bitn   = 0;
  end

  always @(negedge cs_n) begin
    bitn    = 0;
    cmd_sh  = 8'h00;
    addr_sh = 8'h00;
    miso_r  = 1'b0;
  end

  always @(posedge sck) begin
    if (cs_n === 1'b0) begin
      if (bitn < 8)       cmd_sh  = {cmd_sh[6:0], mosi};
      else if (bitn < 16) addr_sh = {addr_sh[6:0], mosi};
      bitn++;
    end
  end

  always @(negedge sck) begin
    if (cs_n === 1'b0 && bitn >= 16 && bitn < 24) miso_r = ram[addr_sh][23 - bitn];
  end

  always @(posedge cs_n) begin
    last_cmd  = cmd_sh;
    last_addr = addr_sh;
    last_bits = bitn;
  end

  // ISA-level reference state
  logic [7:0] m_a, m_b, m_s, m_o, m_pc;
  logic       m_valid, m_skip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_s = 0; m_o = 0; m_pc = 0; m_valid = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    for (int h = 0; h < 2; h++) begin
      n = (h == 0) ? int'(b) / 16 : int'(b) % 16;
      if (m_skip) m_skip = 0;
      else case (n)
        0:  m_a = 8'(int'(ui_in) % 16);
        1:  m_b = 8'(int'(ui_in) / 16);
        2:  begin m_o = m_s; m_valid = 1; end
        3:  m_a = m_s;
        4:  m_b = m_s;
        5:  m_a = 8'((int'(m_a) * 2) % 256);
        6:  m_b = 8'(int'(m_b) / 2);
        7:  begin m_a = 0; m_b = 0; m_s = 0; end
        8:  m_skip = (m_a != 0);
        9:  m_skip = (m_s != 0);
        10: m_s = 8'((int'(m_a) + int'(m_b)) % 256);
        11: m_s = 8'((256 + int'(m_a) - int'(m_b)) % 256);
        12: m_s = m_a & m_b;
        13: m_s = m_a | m_b;
        14: m_s = m_a ^ m_b;
        default: ;
      endcase
    end
  endtask

  task automatic wait_cs(input logic lvl, output int n);
    n = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cs_n === lvl) begin
        n = i + 1;
        break;
      end
    end
    chk("cs_wait", 32'(cs_n), 32'(lvl));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_bytes(input int cnt, input bit rnd_ui, input bit pauses);
    int  n;
    bit  paused;
    for (int k = 0; k < cnt; k++) begin
      wait_cs(1'b0, n);
      if (n < 0) return;
      paused = 0;
      if (pauses && $urandom_range(0, 2) == 0) begin
        paused = 1;
        repeat ($urandom_range(2, 30)) @(negedge clk);
        ena = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        chk("cs_hold_disabled", 32'(cs_n), 32'(0));
        ena = 1'b1;
      end
      wait_cs(1'b1, n);
      if (n < 0) return;
      if (!paused) chk("cs_low_cycles", 32'(n), 32'(48));
      chk("spi_cmd", 32'(last_cmd), 32'h03);
      chk("fetch_addr", 32'(last_addr), 32'(m_pc));
      chk("spi_bits", 32'(last_bits), 32'(24));
      repeat (4) @(posedge clk);
      #1;
      model_byte(ram[m_pc]);
      m_pc = m_pc + 8'd1;
      chk("uo_out", 32'(uo_out), 32'({m_valid, m_o[6:0]}));
      if (rnd_ui) ui_in = 8'($urandom);
      junk = 8'($urandom);
    end
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 256; i++) ram[i] = 8'hFF;
    ram[0] = b0;
    ram[1] = b1;
    ram[2] = b2;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    ui_in = 8'h35;
    junk  = 8'h00;
    load_prog(8'h10, 8'hA2, 8'hFF);
    do_reset();
    #1;
    chk("reset_uo_out", 32'(uo_out), 32'h00);
    chk("reset_uio_out", 32'(uio_out), 32'h01);
`ifdef SPI_CPU_DBG_PC_EN
    chk("uio_oe", 32'(uio_oe), 32'hFB);
`else
    chk("uio_oe", 32'(uio_oe), 32'h0B);
`endif
    repeat (5) @(negedge clk);
    chk("idle_while_disabled", 32'(cs_n), 32'(1));

    // A=5, B=3, ADD, LDO
    ena = 1'b1;
    run_bytes(2, 0, 0);
    chk("add_result", 32'(uo_out), 32'h88);

    // 3 - 5 wraps to 0xFE
    ui_in = 8'h53;
    load_prog(8'h10, 8'hB2, 8'hFF);
    do_reset();
    ena = 1'b1;
    run_bytes(2, 0, 0);
    chk("sub_wrap", 32'(uo_out), 32'hFE);

    // SNZA with A=0 does not skip ADD
    ui_in = 8'h30;
    load_prog(8'h01, 8'h8A, 8'h2F);
    do_reset();
    ena = 1'b1;
    run_bytes(3, 0, 0);
    chk("snza_noskip", 32'(uo_out), 32'h83);

    // SNZA with A=1 skips ADD
    ui_in = 8'h31;
    do_reset();
    ena = 1'b1;
    run_bytes(3, 0, 0);
    chk("snza_skip", 32'(uo_out), 32'h80);

    // skip raised by low nibble drops only the next high nibble
    load_prog(8'h01, 8'h18, 8'hA2);
    do_reset();
    ena = 1'b1;
    run_bytes(3, 0, 0);
    chk("skip_cross_byte", 32'(uo_out), 32'h80);

    // all-NOP program: PC wraps 0xFF -> 0x00
    for (int i = 0; i < 256; i++) ram[i] = 8'hFF;
    ui_in = 8'($urandom);
    do_reset();
    ena = 1'b1;
    run_bytes(258, 1, 0);
    chk("nop_wrap_pc", 32'(last_addr), 32'h01);
    chk("nop_uo_out", 32'(uo_out), 32'h00);

    // random program, random operands, random enable pauses
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[3] = 8'hA2;
    ui_in = 8'($urandom);
    do_reset();
    ena = 1'b1;
    run_bytes(40, 1, 1);

    // async reset in the middle of the DATA phase
    begin
      int n;
      wait_cs(1'b0, n);
      repeat (38) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midreset_cs_n", 32'(cs_n), 32'(1));
      chk("midreset_sck", 32'(sck), 32'(0));
      chk("midreset_uo_out", 32'(uo_out), 32'h00);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run_bytes(2, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cpu_top.md
Name: spi_cpu_top

Overview:
- Tiny 4-bit-opcode CPU that fetches its program byte-by-byte from an external SPI RAM using READ (0x03) with an 8-bit address.
- Each program byte holds two instructions; the high nibble executes first.
- Operands come from ui_in. Results appear on uo_out[6:0], with a valid flag on uo_out[7].
- Top-level TinyTapeout user block; the SPI RAM sits on the uio pins.

Parameters:
- ADDR_BITS, 8, width of the PC and of the SPI address phase (MSB first). The PC wraps modulo 2^ADDR_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ena  in  1  design enable; when 0, the FSM holds in its current state and does not start a new fetch
- ui_in  in  8  operand inputs: [3:0] feed A, [7:4] feed B
- uo_out  out  8  [6:0] = O[6:0]; [7] = valid
- uio_in  in  8  [2] = MISO; other bits ignored
- uio_out  out  8  [0] = CS_N, [1] = MOSI, [3] = SCK; other bits 0
- uio_oe  out  8  constant 8'b0000_1011

Behaviour:
- Registers: A, B, S, O (all 8-bit), PC (ADDR_BITS), IR (8-bit), skip flag, valid.
- Reset values: all registers 0, skip=0, valid=0, CS_N=1, SCK=0, MOSI=0.
- Async reset mid-transaction: CS_N rises immediately.
- SPI mode 0, SCK = clk/2:
  - SCK toggles every enabled clk while CS_N=0.
  - MOSI changes only on the edge that drives SCK low, and before the first rise.
  - MISO is sampled on the clk edge that drives SCK 0→1.
- FSM states: IDLE → CMD (8 bits of 0x03) → ADDR (ADDR_BITS bits of PC) → DATA (8 bits into IR, MSB first) → END (CS_N=1 for ≥2 clk) → EXH → EXL → IDLE.
  - CS_N falls 1 clk before the first SCK rise.
  - PC increments when entering EXH.
  - Fetch latency: 2 + 2·(8+ADDR_BITS+8) clk, i.e. 50 clk at default.
- Each EX state executes one nibble in 1 clk. EXH executes IR[7:4]; EXL executes IR[3:0].
- If skip=1, the nibble is not executed and skip clears. A skip raised by EXL applies to the next byte's high nibble.
- Opcodes:
  - 0 LDA: A ← {4'b0, ui_in[3:0]}
  - 1 LDB: B ← {4'b0, ui_in[7:4]}
  - 2 LDO: O ← S; valid ← 1
  - 3 LDSA: A ← S
  - 4 LDSB: B ← S
  - 5 LSH: A ← A<<1
  - 6 RSH: B ← B>>1
  - 7 CLR: A, B, S ← 0; O and valid unchanged
  - 8 SNZA: skip ← (A≠0)
  - 9 SNZS: skip ← (S≠0)
  - A ADD: S ← A+B, mod 256
  - B SUB: S ← A−B, mod 256
  - C AND: S ← A&B
  - D OR: S ← A|B
  - E XOR: S ← A^B
  - F NOP
- valid stays 1 from the first LDO until reset.
- PC wraps from 255 to 0 and execution continues.

Optional Feature:
- SPI_CPU_DBG_PC_EN:
  - Defined: uio_out[7:4] = PC[3:0] and uio_oe = 8'b1111_1011.
  - Undefined: those bits are 0 and uio_oe = 8'b0000_1011.

Decomposition:
- Package spi_cpu_pkg holds:
  - opcode localparams (OP_LDA … OP_NOP)
  - FSM state enum
  - SPI READ command constant 8'h03
  - uio pin index constants
- Sub-module spi_fetch: SPI master that takes addr and start, and returns byte and done. The top keeps the register file and the executor.

Test Plan:
- Reset then ena=1 → CS_N low; bench captures 0x03 then 0x00 on MOSI; first fetch at addr 0, next at addr 1; uio_oe=0x0B.
- RAM[0]=0x10, RAM[1]=0xA2, ui_in=0x35 → A=5, B=3, S=8, uo_out=0x88 after the second execute.
- RAM[0]=0x10, RAM[1]=0xB2, ui_in=0x53 → S=0xFE (3−5 wraps), uo_out[6:0]=0x7E, valid=1.
- Skip: A=0 with "8 then A" executes ADD; A=1 skips ADD; skip crossing a byte boundary drops the next high nibble only.
- Program of 256 NOP bytes (0xFF) → fetch address goes 0xFF then 0x00; uo_out stays 0x00.
- Assert rst mid-DATA phase → CS_N=1 and SCK=0 immediately; after release, fetch restarts at addr 0.
